// File: rtl/uart_pkg.sv
// ============================================================================
// Module      : uart_pkg
// Description : Shared parity-mode constants and FSM state types for the UART.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam int c_PARITY_NONE = 0;
    localparam int c_PARITY_EVEN = 1;
    localparam int c_PARITY_ODD  = 2;
    localparam int c_MIN_CPB     = 4;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE      = 3'd0,
        RX_START     = 3'd1,
        RX_DATA      = 3'd2,
        RX_PARITY    = 3'd3,
        RX_STOP      = 3'd4,
        RX_WAIT_HIGH = 3'd5
    } rx_state_t;

endpackage

`default_nettype wire

// File: rtl/uart_bit_timer.sv
// ============================================================================
// Module      : uart_bit_timer
// Description : Reloading down-counter; first interval and period latched on start.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int CPB_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [CPB_W-1:0] i_first_len,
    input  logic [CPB_W-1:0] i_period,
    output logic             o_tick
);

    logic [CPB_W-1:0] r_period;
    logic [CPB_W-1:0] r_cnt;

    // o_tick marks the last cycle of each interval; the counter then reloads itself
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_period <= CPB_W'(c_MIN_CPB);
            r_cnt    <= '0;
        end else if (i_start) begin
            r_period <= i_period;
            r_cnt    <= i_first_len - 1'b1;
        end else if (r_cnt == '0) begin
            r_cnt    <= r_period - 1'b1;
        end else begin
            r_cnt    <= r_cnt - 1'b1;
        end
    end

    assign o_tick = (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/uart_transceiver.sv
// ============================================================================
// Module      : uart_transceiver
// Description : Full-duplex UART with runtime baud, optional parity, loopback.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_transceiver
    import uart_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int CPB_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CPB_W-1:0]     clks_per_bit,
    input  logic                 loopback,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx_line,
    input  logic                 rx_line,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 rx_busy
);

    localparam int                 c_BCW       = $clog2(DATA_BITS + 1);
    localparam logic [c_BCW-1:0]   c_LAST_BIT  = c_BCW'(DATA_BITS - 1);
    localparam logic               c_LAST_STOP = (STOP_BITS == 2);
    localparam logic               c_ODD       = (PARITY == c_PARITY_ODD);
    localparam logic               c_HAS_PAR   = (PARITY != c_PARITY_NONE);

    logic [CPB_W-1:0] w_cpb;
    assign w_cpb = (clks_per_bit < CPB_W'(c_MIN_CPB)) ? CPB_W'(c_MIN_CPB) : clks_per_bit;

    // ---------------------------------------------------------------- TX
    tx_state_t            r_tx_state, w_tx_state;
    logic [DATA_BITS-1:0] r_tx_shift, w_tx_shift;
    logic [c_BCW-1:0]     r_tx_bit,   w_tx_bit;
    logic                 r_tx_stop,  w_tx_stop;
    logic                 r_tx_par,   w_tx_par;
    logic                 r_tx_line,  w_tx_line;
    logic                 w_tx_tick, w_tx_done, w_tx_accept;

    uart_bit_timer #(.CPB_W(CPB_W)) u_tx_timer (
        .clk         (clk),
        .rst         (rst),
        .i_start     (w_tx_accept),
        .i_first_len (w_cpb),
        .i_period    (w_cpb),
        .o_tick      (w_tx_tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_state <= TX_IDLE;
            r_tx_shift <= '0;
            r_tx_bit   <= '0;
            r_tx_stop  <= 1'b0;
            r_tx_par   <= 1'b0;
            r_tx_line  <= 1'b1;
        end else begin
            r_tx_state <= w_tx_state;
            r_tx_shift <= w_tx_shift;
            r_tx_bit   <= w_tx_bit;
            r_tx_stop  <= w_tx_stop;
            r_tx_par   <= w_tx_par;
            r_tx_line  <= w_tx_line;
        end
    end

    // The last stop-bit cycle already counts as idle, so a waiting word starts with no gap
    always_comb begin
        w_tx_done   = (r_tx_state == TX_STOP) && w_tx_tick && (r_tx_stop == c_LAST_STOP);
        tx_ready    = !rst && ((r_tx_state == TX_IDLE) || w_tx_done);
        w_tx_accept = tx_valid && tx_ready;
        w_tx_state  = r_tx_state;
        w_tx_shift  = r_tx_shift;
        w_tx_bit    = r_tx_bit;
        w_tx_stop   = r_tx_stop;
        w_tx_par    = r_tx_par;
        w_tx_line   = r_tx_line;
        if (w_tx_accept) begin
            w_tx_state = TX_START;
            w_tx_shift = tx_data;
            w_tx_par   = (^tx_data) ^ c_ODD;
            w_tx_line  = 1'b0;
        end else begin
            case (r_tx_state)
                TX_IDLE: w_tx_line = 1'b1;
                TX_START: if (w_tx_tick) begin
                    w_tx_state = TX_DATA;
                    w_tx_bit   = '0;
                    w_tx_line  = r_tx_shift[0];
                end
                TX_DATA: if (w_tx_tick) begin
                    if (r_tx_bit != c_LAST_BIT) begin
                        w_tx_shift = r_tx_shift >> 1;
                        w_tx_line  = r_tx_shift[1];
                        w_tx_bit   = r_tx_bit + 1'b1;
                    end else if (c_HAS_PAR) begin
                        w_tx_state = TX_PARITY;
                        w_tx_line  = r_tx_par;
                    end else begin
                        w_tx_state = TX_STOP;
                        w_tx_stop  = 1'b0;
                        w_tx_line  = 1'b1;
                    end
                end
                TX_PARITY: if (w_tx_tick) begin
                    w_tx_state = TX_STOP;
                    w_tx_stop  = 1'b0;
                    w_tx_line  = 1'b1;
                end
                TX_STOP: if (w_tx_done) begin
                    w_tx_state = TX_IDLE;
                end else if (w_tx_tick) begin
                    w_tx_stop  = 1'b1;
                end
                default: begin
                    w_tx_state = TX_IDLE;
                    w_tx_line  = 1'b1;
                end
            endcase
        end
    end

    assign tx_line = r_tx_line;

    // ---------------------------------------------------------------- RX
    rx_state_t            r_rx_state, w_rx_state;
    logic [DATA_BITS-1:0] r_rx_shift, w_rx_shift;
    logic [DATA_BITS-1:0] r_rx_data,  w_rx_data;
    logic [c_BCW-1:0]     r_rx_bit,   w_rx_bit;
    logic                 r_rx_par,   w_rx_par;
    logic                 r_par_err,  w_par_err;
    logic                 r_frm_err,  w_frm_err;
    logic                 r_rx_valid, w_rx_valid;
    logic                 r_sync1, r_sync2, r_rx_prev;
    logic                 w_rx_in, w_rx_tick, w_rx_start;

    assign w_rx_in = loopback ? r_tx_line : rx_line;

    uart_bit_timer #(.CPB_W(CPB_W)) u_rx_timer (
        .clk         (clk),
        .rst         (rst),
        .i_start     (w_rx_start),
        .i_first_len (w_cpb >> 1),
        .i_period    (w_cpb),
        .o_tick      (w_rx_tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1    <= 1'b1;
            r_sync2    <= 1'b1;
            r_rx_prev  <= 1'b1;
            r_rx_state <= RX_IDLE;
            r_rx_shift <= '0;
            r_rx_data  <= '0;
            r_rx_bit   <= '0;
            r_rx_par   <= 1'b0;
            r_par_err  <= 1'b0;
            r_frm_err  <= 1'b0;
            r_rx_valid <= 1'b0;
        end else begin
            r_sync1    <= w_rx_in;
            r_sync2    <= r_sync1;
            r_rx_prev  <= r_sync2;
            r_rx_state <= w_rx_state;
            r_rx_shift <= w_rx_shift;
            r_rx_data  <= w_rx_data;
            r_rx_bit   <= w_rx_bit;
            r_rx_par   <= w_rx_par;
            r_par_err  <= w_par_err;
            r_frm_err  <= w_frm_err;
            r_rx_valid <= w_rx_valid;
        end
    end

    always_comb begin
        w_rx_start = (r_rx_state == RX_IDLE) && r_rx_prev && !r_sync2;
        w_rx_state = r_rx_state;
        w_rx_shift = r_rx_shift;
        w_rx_data  = r_rx_data;
        w_rx_bit   = r_rx_bit;
        w_rx_par   = r_rx_par;
        w_par_err  = r_par_err;
        w_frm_err  = r_frm_err;
        w_rx_valid = 1'b0;
        case (r_rx_state)
            RX_IDLE: if (w_rx_start) w_rx_state = RX_START;
            // A start bit that is high again at mid-bit was a glitch
            RX_START: if (w_rx_tick) begin
                if (r_sync2) begin
                    w_rx_state = RX_IDLE;
                end else begin
                    w_rx_state = RX_DATA;
                    w_rx_bit   = '0;
                end
            end
            RX_DATA: if (w_rx_tick) begin
                w_rx_shift = {r_sync2, r_rx_shift[DATA_BITS-1:1]};
                w_rx_bit   = r_rx_bit + 1'b1;
                if (r_rx_bit == c_LAST_BIT) begin
                    if (c_HAS_PAR) w_rx_state = RX_PARITY;
                    else           w_rx_state = RX_STOP;
                end
            end
            RX_PARITY: if (w_rx_tick) begin
                w_rx_par   = r_sync2;
                w_rx_state = RX_STOP;
            end
            RX_STOP: if (w_rx_tick) begin
                w_rx_data  = r_rx_shift;
                w_par_err  = c_HAS_PAR & ((^r_rx_shift) ^ r_rx_par ^ c_ODD);
                w_frm_err  = !r_sync2;
                w_rx_valid = 1'b1;
                if (r_sync2) w_rx_state = RX_IDLE;
                else         w_rx_state = RX_WAIT_HIGH;
            end
            RX_WAIT_HIGH: if (r_sync2) w_rx_state = RX_IDLE;
            default: w_rx_state = RX_IDLE;
        endcase
    end

    assign rx_data    = r_rx_data;
    assign rx_valid   = r_rx_valid;
    assign parity_err = r_par_err;
    assign frame_err  = r_frm_err;
    assign rx_busy    = (r_rx_state != RX_IDLE);

endmodule

`default_nettype wire

// File: doc/uart_transceiver.md
UART_TRANSCEIVER -- requirements
Module: uart_transceiver

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, data bits per frame (legal 5..9).
REQ-002 SHALL have parameter PARITY, default 0, parity mode: 0 none, 1 even, 2 odd.
REQ-003 SHALL have parameter STOP_BITS, default 1, stop bits transmitted (legal 1..2).
REQ-004 SHALL have parameter CPB_W, default 16, width of clks_per_bit.
REQ-005 Ports:
  clk  in  1  single clock for TX and RX
  rst  in  1  reset, asynchronous, active-high
  clks_per_bit  in  CPB_W  clock cycles per bit (runtime baud select)
  loopback  in  1  1 = RX input taken from internal tx_line
  tx_data  in  DATA_BITS  byte to send
  tx_valid  in  1  tx_data valid
  tx_ready  out  1  transmitter accepts a frame
  tx_line  out  1  serial output, idle high
  rx_line  in  1  serial input, asynchronous to clk
  rx_data  out  DATA_BITS  last received word
  rx_valid  out  1  one-cycle pulse: new rx_data
  parity_err  out  1  parity mismatch on last frame
  frame_err  out  1  stop bit low on last frame
  rx_busy  out  1  receiver inside a frame

Function
REQ-006 SHALL latch clks_per_bit at frame start (TX and RX independently); mid-frame changes SHALL NOT affect the current frame; values below 4 SHALL be treated as 4.
REQ-007 TX FSM states SHALL be IDLE, START, DATA, PARITY, STOP; PARITY skipped when PARITY=0.
REQ-008 tx_ready SHALL be 1 only in IDLE; handshake tx_valid && tx_ready SHALL latch tx_data and enter START.
REQ-009 tx_line SHALL go low the cycle after acceptance; each bit SHALL last exactly the latched clks_per_bit cycles.
REQ-010 Data SHALL be sent LSB first; parity bit = XOR of data (even) or its inverse (odd); STOP_BITS high bits follow.
REQ-011 After the last stop-bit cycle TX SHALL return to IDLE; a pending tx_valid SHALL be accepted that cycle, giving zero idle gap between frames.
REQ-012 RX input SHALL be loopback ? tx_line : rx_line, passed through a 2-flop synchroniser before any use.
REQ-013 RX FSM states SHALL be IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
REQ-014 In IDLE, a synchronised 1->0 transition SHALL enter START; after floor(clks_per_bit/2) cycles the line SHALL be resampled; if high, RX SHALL return to IDLE with no output change (glitch rejection).
REQ-015 Subsequent samples SHALL be taken every clks_per_bit cycles from the mid-start point: DATA_BITS data, optional parity, one stop bit (RX checks only the first stop bit).
REQ-016 On the stop-bit sample, rx_data, parity_err, frame_err SHALL update and rx_valid SHALL pulse for exactly one cycle, also when errors are flagged.
REQ-017 rx_data and error flags SHALL hold until the next rx_valid.
REQ-018 If stop bit is low, RX SHALL enter WAIT_HIGH and re-arm only after the synchronised line is high (break handling).
REQ-019 rx_busy SHALL be 1 in every RX state except IDLE.

Reset
REQ-020 rst SHALL asynchronously force: tx_line=1, tx_ready=0 during reset and 1 in the first cycle after, rx_valid=0, rx_data=0, parity_err=0, frame_err=0, rx_busy=0, both FSMs IDLE, synchroniser flops=1.
REQ-021 rst asserted mid-frame SHALL abort both frames; no rx_valid SHALL be emitted for the aborted frame.

Structure
REQ-022 Package uart_pkg SHALL hold parity-mode constants, tx_state_t and rx_state_t enums.
REQ-023 Sub-module uart_bit_timer (load value, start, tick output) SHALL be instantiated once for TX and once for RX.

Verification
REQ-024 Loopback=1, clks_per_bit=16, tx_data=0xA5 -> tx_line 0,1,0,1,0,0,1,0,1,1 at 16-cycle spacing; rx_valid once, rx_data=0xA5, no errors.
REQ-025 PARITY=1, tx_data=0x07 -> parity bit 1; rx_line driven with parity 0 -> rx_valid, parity_err=1, rx_data=0x07.
REQ-026 rx_line held low for 10 bit times (break) -> rx_valid once, rx_data=0x00, frame_err=1; no new frame until line high.
REQ-027 rx_line low pulse of 3 cycles, clks_per_bit=16 -> no rx_valid, rx_busy returns to 0.
REQ-028 tx_valid held high with 0x11 then 0x22 -> second start bit directly follows first stop bit, no idle cycle.
REQ-029 rst asserted during DATA bit 4 -> tx_line=1 immediately, no rx_valid, next frame received correctly.
